btn_event_ctrl: RTL and testbench

Controller that sits behind a bank of debounce blocks and turns their clean button levels into discrete events. Each button has its own state machine for press, release, long-press and auto-repeat. A round-robin arbiter shares a single event output channel between all buttons, using a valid/ready handshake. Downstream consumers (menu FSM, UART reporter) see one ordered event stream instead of N level signals.

---
 rtl/btn_event_pkg.sv | 29 ++
 rtl/btn_event_fsm.sv | 96 +++++++++
 rtl/btn_event_ctrl.sv | 146 ++++++++++++++
 tb/tb_btn_event_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared types for the button event controller.
//   ev_type_t   : event codes as they appear on ev_type
//                 (PRESS=00, RELEASE=01, LONG=10, REPEAT=11)
//   btn_state_t : per-button state machine states (IDLE, PRESS, HOLD)
//   rr_idx_w()  : width of a button index / round-robin pointer; at least 1 bit
//                 so that a single-button build still has a real ev_id port.
// -----------------------------------------------------------------------------
package btn_event_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRESS = 2'b01,
    ST_HOLD  = 2'b10
  } btn_state_t;

  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// -----------------------------------------------------------------------------
// btn_event_fsm
// Per-button press / release / long-press / auto-repeat state machine.
// Produces a single-cycle post strobe with the event type; the strobe is
// combinational so the owning slot is written on the same clock edge that
// sampled the button level.
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   btn_i       : debounced button level, 1 = pressed
//   post_o      : an event is generated this cycle
//   post_type_o : type of the generated event (ev_type_t encoding)
// -----------------------------------------------------------------------------
module btn_event_fsm
  import btn_event_pkg::*;
#(
  parameter int LONG_CYC   = 1000,
  parameter int REPEAT_CYC = 200,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic       post_o,
  output logic [1:0] post_type_o
);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Release is tested before the threshold so that letting go on the very
  // cycle the counter hits its limit yields only RELEASE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    post_o      = 1'b0;
    post_type_o = EV_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (btn_i) begin
          state_d     = ST_PRESS;
          cnt_d       = '0;
          post_o      = 1'b1;
          post_type_o = EV_PRESS;
        end
      end
      ST_PRESS: begin
        if (!btn_i) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          post_o      = 1'b1;
          post_type_o = EV_RELEASE;
        end else if (cnt_q == LONG_LAST) begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          post_o      = 1'b1;
          post_type_o = EV_LONG;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (!btn_i) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          post_o      = 1'b1;
          post_type_o = EV_RELEASE;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d       = '0;
          post_o      = 1'b1;
          post_type_o = EV_REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl
// Turns NBTN debounced button levels into a single ordered event stream.
// Each button owns a one-entry event slot; a round-robin arbiter moves slot
// contents into a registered valid/ready output stage.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   btn_db   : debounced button levels, 1 = pressed
//   ev_valid : event available on ev_id / ev_type
//   ev_ready : consumer accepts the event when ev_valid && ev_ready
//   ev_id    : index of the button that generated the event
//   ev_type  : 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   pending  : per-button slot occupied
//   ev_drop  : one-cycle pulse after an unserved slot was overwritten
// -----------------------------------------------------------------------------
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int NBTN       = 4,
  parameter int LONG_CYC   = 1000,
  parameter int REPEAT_CYC = 200,
  parameter int CW         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NBTN-1:0]            btn_db,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [rr_idx_w(NBTN)-1:0]  ev_id,
  output logic [1:0]                 ev_type,
  output logic [NBTN-1:0]            pending,
  output logic                       ev_drop
);

  localparam int IW = rr_idx_w(NBTN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBTN - 1);

  logic [NBTN-1:0] post;
  logic [1:0]      post_type [NBTN];

  logic [NBTN-1:0] pending_q, pending_d;
  logic [NBTN-1:0] grant, drop;
  logic [1:0]      slot_q [NBTN];
  logic [1:0]      slot_d [NBTN];

  logic [IW-1:0]   ptr_q, ptr_next;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            load;

  logic            ev_valid_q;
  logic [IW-1:0]   ev_id_q;
  logic [1:0]      ev_type_q;
  logic            ev_drop_q;

  // ---------------------------------------------------------------------------
  // Per-button FSMs and slot next-state
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      btn_event_fsm #(
        .LONG_CYC   (LONG_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .CW         (CW)
      ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .btn_i       (btn_db[gi]),
        .post_o      (post[gi]),
        .post_type_o (post_type[gi])
      );

      assign grant[gi] = load && win_found && (win_idx == IW'(gi));
      // A slot being granted on this edge hands its old content to the output
      // register, so a simultaneous new event is not a loss.
      assign drop[gi]      = post[gi] && pending_q[gi] && !grant[gi];
      assign pending_d[gi] = post[gi] | (pending_q[gi] & ~grant[gi]);
      assign slot_d[gi]    = post[gi] ? post_type[gi] : slot_q[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin search: first pending slot at or above ptr_q, with wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NBTN; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NBTN) begin
        j = j - NBTN;
      end
      if (!win_found && pending_q[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  assign ptr_next = (win_idx == LAST_IDX) ? '0 : (win_idx + IW'(1));

  // The output stage can take a new event when empty or when the current one
  // is being consumed, giving one event per cycle under continuous ready.
  assign load = !ev_valid_q || ev_ready;

  // ---------------------------------------------------------------------------
  // Slot, pointer and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      for (int i = 0; i < NBTN; i++) begin
        slot_q[i] <= EV_PRESS;
      end
      ptr_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      ev_type_q  <= EV_PRESS;
      ev_drop_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      slot_q    <= slot_d;
      ev_drop_q <= |drop;
      if (load) begin
        if (win_found) begin
          ev_valid_q <= 1'b1;
          ev_id_q    <= win_idx;
          ev_type_q  <= slot_q[win_idx];
          ptr_q      <= ptr_next;
        end else begin
          ev_valid_q <= 1'b0;
        end
      end
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign ev_type  = ev_type_q;
  assign pending  = pending_q;
  assign ev_drop  = ev_drop_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_event_ctrl
// Directed scenarios followed by random button/ready/reset traffic, all
// compared cycle by cycle against a behavioural model that tracks how long
// each button has been held and a simple slot/queue view of the arbiter.
// -----------------------------------------------------------------------------
module tb_btn_event_ctrl;

  localparam int NBTN       = 4;
  localparam int LONG_CYC   = 8;
  localparam int REPEAT_CYC = 4;
  localparam int CW         = 8;
  localparam int IW         = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NBTN-1:0] btn_db = '0;
  logic            ev_ready = 1'b1;
  logic            ev_valid;
  logic [IW-1:0]   ev_id;
  logic [1:0]      ev_type;
  logic [NBTN-1:0] pending;
  logic            ev_drop;

  btn_event_ctrl #(
    .NBTN       (NBTN),
    .LONG_CYC   (LONG_CYC),
    .REPEAT_CYC (REPEAT_CYC),
    .CW         (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_db   (btn_db),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .ev_type  (ev_type),
    .pending  (pending),
    .ev_drop  (ev_drop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", tag, cycle, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_held [NBTN];
  int m_age  [NBTN];   // cycles since this button's PRESS was posted
  bit m_pend [NBTN];
  int m_slot [NBTN];
  bit m_valid;
  int m_id, m_type, m_ptr;
  bit m_drop;

  task automatic model_reset();
    for (int b = 0; b < NBTN; b++) begin
      m_held[b] = 0; m_age[b] = 0; m_pend[b] = 0; m_slot[b] = 0;
    end
    m_valid = 0; m_id = 0; m_type = 0; m_ptr = 0; m_drop = 0;
  endtask

  // Evaluate one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int ev [NBTN];
    int win;
    bit ld;
    if (rst) begin
      model_reset();
      return;
    end
    // events from the hold-time rules
    for (int b = 0; b < NBTN; b++) begin
      ev[b] = -1;
      if (!m_held[b] && btn_db[b]) begin
        ev[b] = 0; m_held[b] = 1; m_age[b] = 0;
      end else if (m_held[b] && !btn_db[b]) begin
        ev[b] = 1; m_held[b] = 0;
      end else if (m_held[b]) begin
        m_age[b]++;
        if (m_age[b] == LONG_CYC) ev[b] = 2;
        else if (m_age[b] > LONG_CYC && ((m_age[b] - LONG_CYC) % REPEAT_CYC) == 0) ev[b] = 3;
      end
    end
    // arbitration on the slot contents before this edge
    ld  = !m_valid || ev_ready;
    win = -1;
    if (ld) begin
      for (int k = 0; k < NBTN; k++) begin
        if (win < 0 && m_pend[(m_ptr + k) % NBTN]) win = (m_ptr + k) % NBTN;
      end
      if (win >= 0) begin
        m_valid = 1; m_id = win; m_type = m_slot[win];
        m_pend[win] = 0; m_ptr = (win + 1) % NBTN;
      end else begin
        m_valid = 0;
      end
    end
    m_drop = 0;
    for (int b = 0; b < NBTN; b++) begin
      if (ev[b] >= 0) begin
        if (m_pend[b]) m_drop = 1;
        m_pend[b] = 1; m_slot[b] = ev[b];
      end
    end
  endtask

  task automatic step();
    logic [NBTN-1:0] mp;
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    for (int b = 0; b < NBTN; b++) mp[b] = m_pend[b];
    check_val("ev_valid", 32'(ev_valid), 32'(m_valid));
    if (m_valid) begin
      check_val("ev_id", 32'(ev_id), 32'(m_id));
      check_val("ev_type", 32'(ev_type), 32'(m_type));
    end
    check_val("pending", 32'(pending), 32'(mp));
    check_val("ev_drop", 32'(ev_drop), 32'(m_drop));
    if (ev_valid && ev_ready)
      $display("cycle=%0d event id=%0d type=%0d", cycle, ev_id, ev_type);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    // reset state
    rst = 1'b1; hold(2);
    rst = 1'b0; hold(2);

    // 1: short press on button 2
    ev_ready = 1'b1;
    btn_db[2] = 1'b1; hold(3);
    btn_db[2] = 1'b0; hold(6);

    // 2: long hold on button 1 with repeats
    btn_db[1] = 1'b1; hold(20);
    btn_db[1] = 1'b0; hold(4);

    // 3: simultaneous presses, twice
    btn_db = 4'b1001; hold(3);
    btn_db = 4'b0000; hold(3);
    btn_db = 4'b1001; hold(3);
    btn_db = 4'b0000; hold(4);

    // 4: back-pressure and slot overwrite
    ev_ready = 1'b0;
    btn_db[1] = 1'b1; hold(2);
    btn_db[1] = 1'b0; hold(2);
    btn_db[1] = 1'b1; hold(2);
    ev_ready = 1'b1; hold(4);
    btn_db[1] = 1'b0; hold(4);

    // 5: reset while an event is held and a button is in HOLD
    btn_db[3] = 1'b1; hold(LONG_CYC + 2);
    ev_ready = 1'b0; hold(2);
    rst = 1'b1; hold(1);
    rst = 1'b0; ev_ready = 1'b1; hold(4);
    btn_db[3] = 1'b0; hold(3);

    // 6: release exactly when LONG would fire
    btn_db[0] = 1'b1; hold(LONG_CYC);
    btn_db[0] = 1'b0; hold(4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) btn_db[$urandom_range(0, NBTN - 1)] ^= 1'b1;
      ev_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
